qam_mapper_stream: RTL and testbench

//  Parametrised, runtime-configurable square-QAM symbol mapper with valid/ready

---
 rtl/qam_mapper_stream.sv | 143 ++++++++++++++
 tb/tb_qam_mapper_stream.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_mapper_stream.sv
// Square-QAM symbol mapper with valid/ready handshakes on both sides.
// Two-stage elastic pipeline: S1 holds the mapped levels, S2 is the output register.
// Each beat is mapped with the constellation order it arrived with.
module qam_mapper_stream #(
  parameter int unsigned M_MAX = 256,
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 1,
  parameter bit          GRAY  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(M_MAX)*N-1:0]   in_data,
  input  logic [1:0]                   in_order,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [W*N-1:0]               re_out,
  output logic [W*N-1:0]               im_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         cfg_err,
  output logic [31:0]                  sym_count
);

  localparam int unsigned B = $clog2(M_MAX);  // bits per symbol at the largest order
  localparam int unsigned A = B / 2;          // bits per axis at the largest order

  logic             s1_valid_q, s1_valid_d;
  logic [W*N-1:0]   s1_re_q, s1_re_d;
  logic [W*N-1:0]   s1_im_q, s1_im_d;
  logic             s2_valid_q, s2_valid_d;
  logic [W*N-1:0]   s2_re_q, s2_re_d;
  logic [W*N-1:0]   s2_im_q, s2_im_d;
  logic             cfg_err_q, cfg_err_d;
  logic [31:0]      sym_count_q, sym_count_d;

  logic             out_fire;
  logic             s2_ready;
  logic             s1_advance;
  logic             accept;
  logic             order_bad;
  int unsigned      a_eff;
  logic [B-1:0]     lane;

  // Map the low a bits of src to one signed axis level, scaled so every order
  // reaches the same peak amplitude; neg flips the axis (used for Q).
  function automatic logic [W-1:0] map_axis(input logic [B-1:0] src,
                                            input int unsigned a,
                                            input logic neg);
    logic [A-1:0] g;
    logic [A-1:0] idx;
    int           v;
    g   = '0;
    idx = '0;
    for (int unsigned i = 0; i < A; i++) begin
      if (i < a) g[i] = src[i];
    end
    if (GRAY) begin
      // bits above a are zero, so a full-width Gray decode is exact
      for (int unsigned i = 0; i < A; i++) idx[i] = ^(g >> i);
    end else begin
      idx = g;
    end
    v = 2 * int'(idx) - (1 << a) + 1;
    v = v <<< (A - a);
    if (neg) v = -v;
    return v[W-1:0];
  endfunction

  // Handshake control, per-lane mapping into S1, S1->S2 transfer, status counters.
  always_comb begin
    out_fire    = s2_valid_q & out_ready;
    s2_ready    = ~s2_valid_q | out_ready;
    s1_advance  = s1_valid_q & s2_ready;
    in_ready    = ~s1_valid_q | s1_advance;
    accept      = in_valid & in_ready;

    a_eff       = 32'(in_order) + 32'd1;
    order_bad   = (a_eff > A);
    if (order_bad) a_eff = A;

    s1_valid_d  = s1_valid_q;
    s1_re_d     = s1_re_q;
    s1_im_d     = s1_im_q;
    s2_valid_d  = s2_valid_q;
    s2_re_d     = s2_re_q;
    s2_im_d     = s2_im_q;
    cfg_err_d   = cfg_err_q;
    sym_count_d = sym_count_q;
    lane        = '0;

    if (accept) begin
      s1_valid_d = 1'b1;
      for (int unsigned l = 0; l < N; l++) begin
        lane = in_data[B*l +: B];
        s1_re_d[W*l +: W] = map_axis(lane, a_eff, 1'b0);
        s1_im_d[W*l +: W] = map_axis(lane >> a_eff, a_eff, 1'b1);
      end
      if (order_bad) cfg_err_d = 1'b1;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    if (s1_advance) begin
      s2_valid_d = 1'b1;
      s2_re_d    = s1_re_q;
      s2_im_d    = s1_im_q;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end

    if (out_fire) sym_count_d = sym_count_q + 32'd1;
  end

  // Pipeline and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_re_q     <= '0;
      s2_im_q     <= '0;
      cfg_err_q   <= 1'b0;
      sym_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_re_q     <= s1_re_d;
      s1_im_q     <= s1_im_d;
      s2_valid_q  <= s2_valid_d;
      s2_re_q     <= s2_re_d;
      s2_im_q     <= s2_im_d;
      cfg_err_q   <= cfg_err_d;
      sym_count_q <= sym_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign re_out    = s2_re_q;
  assign im_out    = s2_im_q;
  assign cfg_err   = cfg_err_q;
  assign sym_count = sym_count_q;

endmodule

// File: tb/tb_qam_mapper_stream.sv
// Scoreboard bench: two 2-lane 256-QAM mappers (binary and Gray) share one input
// stream; a 64-QAM mapper exercises order clamping and the sticky error flag.
module tb_qam_mapper_stream;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } exp_t;

  typedef struct packed {
    logic [1:0]  ord;
    logic [15:0] dat;
    logic [15:0] re0;
    logic [15:0] im0;
    logic [15:0] re1;
    logic [15:0] im1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data;
  logic [1:0]  in_order;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready0, in_ready1, in_ready2;
  logic [15:0] re0, im0, re1, im1;
  logic [7:0]  re2, im2;
  logic        ov0, ov1, ov2;
  logic        ce0, ce1, ce2;
  logic [31:0] sc0, sc1, sc2;
  logic [5:0]  in_data2;
  logic [1:0]  in_order2;
  logic        in_valid2;

  int errors = 0;
  int checks = 0;

  exp_t        q [3][$];
  exp_t        e;
  vec_t        vt [10];
  logic        stall_prev [3];
  logic [15:0] pre_re [3];
  logic [15:0] pre_im [3];
  logic [15:0] re_a [3];
  logic [15:0] im_a [3];
  logic        ov_a [3];

  always #5 clk = ~clk;

  qam_mapper_stream #(.M_MAX(256), .W(8), .N(2), .GRAY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_order(in_order), .in_valid(in_valid),
    .in_ready(in_ready0), .re_out(re0), .im_out(im0), .out_valid(ov0), .out_ready(out_ready),
    .cfg_err(ce0), .sym_count(sc0));

  qam_mapper_stream #(.M_MAX(256), .W(8), .N(2), .GRAY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_order(in_order), .in_valid(in_valid),
    .in_ready(in_ready1), .re_out(re1), .im_out(im1), .out_valid(ov1), .out_ready(out_ready),
    .cfg_err(ce1), .sym_count(sc1));

  qam_mapper_stream #(.M_MAX(64), .W(8), .N(1), .GRAY(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_order(in_order2), .in_valid(in_valid2),
    .in_ready(in_ready2), .re_out(re2), .im_out(im2), .out_valid(ov2), .out_ready(out_ready),
    .cfg_err(ce2), .sym_count(sc2));

  assign re_a[0] = re0;
  assign im_a[0] = im0;
  assign ov_a[0] = ov0;
  assign re_a[1] = re1;
  assign im_a[1] = im1;
  assign ov_a[1] = ov1;
  assign re_a[2] = {8'h00, re2};
  assign im_a[2] = {8'h00, im2};
  assign ov_a[2] = ov2;

  function automatic logic [15:0] pk(input int l0, input int l1);
    return {l1[7:0], l0[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every output handshake; check hold while stalled.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        stall_prev[k] = 1'b0;
      end else begin
        if (stall_prev[k]) begin
          chk($sformatf("hold_valid%0d", k), 32'(ov_a[k]), 32'd1);
          chk($sformatf("hold_re%0d", k), 32'(re_a[k]), 32'(pre_re[k]));
          chk($sformatf("hold_im%0d", k), 32'(im_a[k]), 32'(pre_im[k]));
        end
        if (ov_a[k] && out_ready) begin
          if (q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious%0d: got output re=%h im=%h, expected none", k, re_a[k], im_a[k]);
          end else begin
            e = q[k].pop_front();
            chk($sformatf("re%0d", k), 32'(re_a[k]), 32'(e.re));
            chk($sformatf("im%0d", k), 32'(im_a[k]), 32'(e.im));
          end
        end
        stall_prev[k] = ov_a[k] && !out_ready;
        pre_re[k]     = re_a[k];
        pre_im[k]     = im_a[k];
      end
    end
  end

  task automatic send_vec(input int k);
    bit ok;
    int n;
    in_order = vt[k].ord;
    in_data  = vt[k].dat;
    in_valid = 1'b1;
    q[0].push_back('{re: vt[k].re0, im: vt[k].im0});
    q[1].push_back('{re: vt[k].re1, im: vt[k].im1});
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready0;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end
  endtask

  task automatic send2(input logic [1:0] ord, input logic [5:0] dat, input int r, input int i);
    bit ok;
    int n;
    in_order2 = ord;
    in_data2  = dat;
    in_valid2 = 1'b1;
    q[2].push_back('{re: pk(r, 0), im: pk(i, 0)});
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready2;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid2 = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout2: in_ready stayed 0, expected 1");
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", 32'(q[0].size() + q[1].size() + q[2].size()), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) q[k].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    // order, {lane1,lane0}, binary re/im, Gray re/im (each packed as pk(lane0, lane1))
    vt[0] = '{2'd1, 16'h0200, pk(-12,   4), pk( 12,  12), pk(-12,  12), pk( 12,  12)};
    vt[1] = '{2'd3, 16'h5AFF, pk( 15,   5), pk(-15,   5), pk(  5,   9), pk( -5,   3)};
    vt[2] = '{2'd0, 16'hFE01, pk(  8,  -8), pk(  8,  -8), pk(  8,  -8), pk(  8,  -8)};
    vt[3] = '{2'd2, 16'h2C3F, pk( 14,   2), pk(-14,  -6), pk(  6,  14), pk( -6, -10)};
    vt[4] = '{2'd1, 16'h09C7, pk( 12,  -4), pk(  4,  -4), pk(  4,  -4), pk(  4, -12)};
    vt[5] = '{2'd3, 16'h8100, pk(-15, -13), pk( 15,  -1), pk(-15, -13), pk( 15, -15)};
    vt[6] = '{2'd2, 16'h310A, pk( -6, -10), pk( 10, -10), pk( -2, -10), pk( 10,  -2)};
    vt[7] = '{2'd0, 16'h0302, pk( -8,   8), pk( -8,  -8), pk( -8,   8), pk( -8,  -8)};
    vt[8] = '{2'd1, 16'h060F, pk( 12,   4), pk(-12,   4), pk(  4,  12), pk( -4,   4)};
    vt[9] = '{2'd3, 16'hB37E, pk( 13,  -9), pk(  1,  -7), pk(  7, -11), pk(  5, -11)};

    in_valid  = 1'b0;
    in_data   = '0;
    in_order  = '0;
    in_valid2 = 1'b0;
    in_data2  = '0;
    in_order2 = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_re", 32'(re0), 32'd0);
    chk("rst_im", 32'(im0), 32'd0);
    chk("rst_cfg_err", 32'(ce0), 32'd0);
    chk("rst_sym_count", sc0, 32'd0);
    chk("rst_in_ready", 32'(in_ready0), 32'd1);

    // Ten back-to-back beats with a three-cycle downstream stall.
    fork
      begin
        for (int k = 0; k < 10; k++) send_vec(k);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready0), 32'd0);
        chk("stall_out_valid", 32'(ov0), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("stream_sym_count0", sc0, 32'd10);
    chk("stream_sym_count1", sc1, 32'd10);

    // Latency: accept edge -> one edge later out_valid rises.
    send_vec(0);
    in_valid = 1'b0;
    chk("lat_not_yet", 32'(ov0), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 32'(ov0), 32'd1);
    wait_drain();
    chk("lat_sym_count", sc0, 32'd11);

    // Reset with two beats in flight discards them.
    out_ready = 1'b0;
    send_vec(1);
    send_vec(2);
    in_valid = 1'b0;
    chk("inflight_full", 32'(in_ready0), 32'd0);
    pulse_reset();
    chk("midrst_out_valid", 32'(ov0), 32'd0);
    chk("midrst_sym_count", sc0, 32'd0);
    chk("midrst_in_ready", 32'(in_ready0), 32'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_output", sc0, 32'd0);

    // 64-QAM instance: normal orders, then clamped order 3 and sticky error.
    send2(2'd2, 6'b010001, -5, 3);
    send2(2'd0, 6'b000010, -4, -4);
    wait_drain();
    chk("cfg_err_clear", 32'(ce2), 32'd0);
    send2(2'd3, 6'b000101, 3, 7);
    chk("cfg_err_set", 32'(ce2), 32'd1);
    send2(2'd1, 6'b000011, 6, 6);
    wait_drain();
    chk("cfg_err_sticky", 32'(ce2), 32'd1);
    chk("m64_sym_count", sc2, 32'd4);
    chk("m256_no_cfg_err", 32'(ce0), 32'd0);
    pulse_reset();
    chk("cfg_err_rst", 32'(ce2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
